// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe-collision game stage.
package pipe_pkg;
  localparam int GRID = 16;

  typedef logic [GRID-1:0][GRID-1:0] grid_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HIT,
    OVER
  } state_e;
endpackage

// File: rtl/pipe_collide_bcd_count2.sv
// Two-digit BCD score counter: clears on clr, saturates at 99.
module bcd_count2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= 8'h00;
    end else if (inc && count != 8'h99) begin
      if (count[3:0] == 4'd9) begin
        count <= {count[7:4] + 4'd1, 4'd0};
      end else begin
        count[3:0] <= count[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_collide.sv
// Game-state FSM: detects bird/pipe collisions, scores passed pipes and
// times the hit flash before game over.
module pipe_collide
  import pipe_pkg::*;
#(
  parameter int BIRD_COL  = 12,
  parameter int HIT_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  grid_t      pipe_position,
  input  logic [3:0] bird_row,
  output logic       playing,
  output logic       hit_flash,
  output logic       game_over,
  output logic [7:0] score_bcd
);

  localparam int CW = $clog2(HIT_TICKS + 1);

  state_e          state;
  logic            occ;
  logic            occ_q;
  logic            collision;
  logic            pass_evt;
  logic            new_game;
  logic [CW-1:0]   hit_cnt;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    occ = 1'b0;
    for (int r = 0; r < GRID; r++) begin
      occ = occ | pipe_position[r][BIRD_COL];
    end
    collision = pipe_position[bird_row][BIRD_COL];
  end

  // A pipe has cleared the bird once its column empties on a game step.
  assign pass_evt = (state == PLAY) && tick && occ_q && !occ && !collision;
  assign new_game = start && (state == IDLE || state == OVER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      occ_q     <= 1'b0;
      hit_cnt   <= '0;
      playing   <= 1'b0;
      hit_flash <= 1'b0;
      game_over <= 1'b0;
    end else begin
      if (tick) occ_q <= occ;
      case (state)
        IDLE: if (start) begin
          state   <= PLAY;
          occ_q   <= 1'b0;
          playing <= 1'b1;
        end
        PLAY: if (collision) begin
          state     <= HIT;
          hit_cnt   <= '0;
          playing   <= 1'b0;
          hit_flash <= 1'b1;
        end
        HIT: if (tick) begin
          if (hit_cnt == CW'(HIT_TICKS - 1)) begin
            state     <= OVER;
            hit_flash <= 1'b0;
            game_over <= 1'b1;
          end else begin
            hit_cnt <= hit_cnt + CW'(1);
          end
        end
        OVER: if (start) begin
          state     <= PLAY;
          occ_q     <= 1'b0;
          game_over <= 1'b0;
          playing   <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          playing   <= 1'b0;
          hit_flash <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  bcd_count2 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (new_game),
    .inc   (pass_evt),
    .count (score_bcd)
  );

endmodule

// File: tb/tb_pipe_collide.sv
// Directed scenarios plus randomized play checked against a decimal-score
// game model.
module tb_pipe_collide;

  localparam int BIRD_COL  = 12;
  localparam int HIT_TICKS = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              tick;
  logic [15:0][15:0] grid;
  logic [3:0]        bird_row;
  logic              playing;
  logic              hit_flash;
  logic              game_over;
  logic [7:0]        score_bcd;

  int checks = 0;
  int errors = 0;

  typedef enum {M_IDLE, M_PLAY, M_HIT, M_OVER} m_state_e;
  m_state_e m_state = M_IDLE;
  int       m_score = 0;
  bit       m_occ_q = 1'b0;
  int       m_hits  = 0;

  pipe_collide #(.BIRD_COL(BIRD_COL), .HIT_TICKS(HIT_TICKS)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .tick          (tick),
    .pipe_position (grid),
    .bird_row      (bird_row),
    .playing       (playing),
    .hit_flash     (hit_flash),
    .game_over     (game_over),
    .score_bcd     (score_bcd)
  );

  always #5 clk = ~clk;

  // Game rules applied to the inputs present just before the edge.
  task automatic model_update();
    bit coll, occ, nocc;
    coll = grid[bird_row][BIRD_COL];
    occ  = 1'b0;
    for (int r = 0; r < 16; r++) occ |= grid[r][BIRD_COL];
    if (reset) begin
      m_state = M_IDLE;
      m_score = 0;
      m_occ_q = 1'b0;
      m_hits  = 0;
    end else begin
      nocc = tick ? occ : m_occ_q;
      case (m_state)
        M_IDLE: if (start) begin m_state = M_PLAY; m_score = 0; nocc = 1'b0; end
        M_PLAY: begin
          if (coll) begin
            m_state = M_HIT;
            m_hits  = 0;
          end else if (tick && m_occ_q && !occ) begin
            m_score = (m_score < 99) ? m_score + 1 : 99;
          end
        end
        M_HIT: if (tick) begin
          m_hits++;
          if (m_hits == HIT_TICKS) m_state = M_OVER;
        end
        M_OVER: if (start) begin m_state = M_PLAY; m_score = 0; nocc = 1'b0; end
        default: m_state = M_IDLE;
      endcase
      m_occ_q = nocc;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One pipe crossing: column occupied away from the bird, then clear.
  task automatic pass_once();
    grid = '0;
    grid[8][BIRD_COL] = 1'b1;
    pulse_tick();
    grid = '0;
    pulse_tick();
  endtask

  task automatic expect_flags(string name, logic p, logic h, logic o, logic [7:0] s);
    checks++;
    if ({playing, hit_flash, game_over} !== {p, h, o} || score_bcd !== s) begin
      errors++;
      $display("FAIL %s: got p/h/o=%b%b%b score=%h, want %b%b%b score=%h",
               name, playing, hit_flash, game_over, score_bcd, p, h, o, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tick = 1'b0; grid = '0; bird_row = 4'd0;
    step();
    step();
    reset = 1'b0;
    expect_flags("reset_state", 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_start();
    pulse_start();
    expect_flags("start_to_play", 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_pass();
    bird_row = 4'd2;
    grid = '0;
    for (int r = 4; r < 16; r++) grid[r][BIRD_COL] = 1'b1;
    pulse_tick();
    expect_flags("pass_occupied", 1'b1, 1'b0, 1'b0, 8'h00);
    grid = '0;
    for (int r = 4; r < 16; r++) grid[r][BIRD_COL + 1] = 1'b1;
    pulse_tick();
    expect_flags("pass_scored", 1'b1, 1'b0, 1'b0, 8'h01);
  endtask

  task automatic test_hit();
    bird_row = 4'd5;
    grid = '0;
    grid[5][BIRD_COL] = 1'b1;
    step();
    grid = '0;
    expect_flags("hit_entered", 1'b0, 1'b1, 1'b0, 8'h01);
    for (int i = 0; i < HIT_TICKS - 1; i++) begin
      pulse_tick();
      step();
    end
    expect_flags("hit_before_last_tick", 1'b0, 1'b1, 1'b0, 8'h01);
    pulse_tick();
    expect_flags("over_after_ticks", 1'b0, 1'b0, 1'b1, 8'h01);
    step();
    expect_flags("over_holds_score", 1'b0, 1'b0, 1'b1, 8'h01);
  endtask

  // Collision on the very tick where occ_q is primed: HIT wins, no increment.
  task automatic test_same_clk();
    bird_row = 4'd3;
    pulse_start();
    pass_once();
    expect_flags("same_clk_setup", 1'b1, 1'b0, 1'b0, 8'h01);
    grid = '0;
    grid[8][BIRD_COL] = 1'b1;
    pulse_tick();
    grid = '0;
    grid[3][BIRD_COL] = 1'b1;
    pulse_tick();
    grid = '0;
    expect_flags("same_clk_hit", 1'b0, 1'b1, 1'b0, 8'h01);
    repeat (HIT_TICKS) pulse_tick();
    expect_flags("same_clk_over", 1'b0, 1'b0, 1'b1, 8'h01);
  endtask

  task automatic test_saturate();
    bird_row = 4'd0;
    pulse_start();
    expect_flags("restart_clears", 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (9) pass_once();
    expect_flags("score_09", 1'b1, 1'b0, 1'b0, 8'h09);
    pass_once();
    expect_flags("carry_10", 1'b1, 1'b0, 1'b0, 8'h10);
    repeat (88) pass_once();
    expect_flags("score_98", 1'b1, 1'b0, 1'b0, 8'h98);
    pass_once();
    pass_once();
    expect_flags("score_99", 1'b1, 1'b0, 1'b0, 8'h99);
    pass_once();
    expect_flags("saturate_99", 1'b1, 1'b0, 1'b0, 8'h99);
  endtask

  task automatic test_reset_mid_hit();
    bird_row = 4'd7;
    grid = '0;
    grid[7][BIRD_COL] = 1'b1;
    step();
    grid = '0;
    pulse_tick();
    pulse_tick();
    expect_flags("mid_hit", 1'b0, 1'b1, 1'b0, 8'h99);
    reset = 1'b1;
    tick  = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0; tick = 1'b0; start = 1'b0;
    expect_flags("reset_mid_hit", 1'b0, 1'b0, 1'b0, 8'h00);
    pulse_start();
    pass_once();
    grid[7][BIRD_COL] = 1'b1;
    step();
    grid = '0;
    repeat (HIT_TICKS) pulse_tick();
    expect_flags("over_again", 1'b0, 1'b0, 1'b1, 8'h01);
    pulse_start();
    expect_flags("start_from_over", 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    bit       exp_p, exp_h, exp_o;
    logic [7:0] exp_s;
    int       gap;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 19) == 0);
      tick  = ($urandom_range(0, 2) == 0);
      bird_row = 4'($urandom_range(0, 15));
      for (int r = 0; r < 16; r++) grid[r] = 16'($urandom);
      gap = $urandom_range(0, 12);
      for (int r = 0; r < 16; r++)
        grid[r][BIRD_COL] = ($urandom_range(0, 3) == 0) && (r < gap || r >= gap + 4);
      step();
      exp_p = (m_state == M_PLAY);
      exp_h = (m_state == M_HIT);
      exp_o = (m_state == M_OVER);
      exp_s = 8'(((m_score / 10) << 4) | (m_score % 10));
      checks++;
      if ({playing, hit_flash, game_over} !== {exp_p, exp_h, exp_o} || score_bcd !== exp_s) begin
        errors++;
        $display("FAIL random[%0d]: got p/h/o=%b%b%b score=%h, want %b%b%b score=%h",
                 n, playing, hit_flash, game_over, score_bcd, exp_p, exp_h, exp_o, exp_s);
      end
    end
    reset = 1'b0; start = 1'b0; tick = 1'b0; grid = '0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_pass();
    test_hit();
    test_same_clk();
    test_saturate();
    test_reset_mid_hit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
